// File: rtl/reset_stretcher.sv
// rtl/reset_stretcher.sv - holds reset_out high for RESET_CYCLES clock_in edges after reset is released.
module reset_stretcher #(
  parameter int RESET_CYCLES = 16
) (
  input  logic clock_in,
  input  logic reset,
  output logic reset_out
);

  localparam int W = $clog2(RESET_CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(RESET_CYCLES);

  // Initial values make the block self-reset after FPGA configuration.
  logic [W-1:0] rcnt = LOAD;
  logic         reset_q = 1'b1;

  always_ff @(posedge clock_in) begin
    reset_q <= reset | (rcnt != '0);
    if (reset) begin
      rcnt <= LOAD;
    end else if (rcnt != '0) begin
      rcnt <= rcnt - 1'b1;
    end
  end

  assign reset_out = reset_q;

endmodule

// File: rtl/clockworks.sv
// rtl/clockworks.sv - divides clock_in by 2^SLOW, emits a per-period tick and a stretched reset.
module clockworks #(
  parameter int SLOW         = 0,
  parameter int RESET_CYCLES = 16
) (
  input  logic clock_in,
  input  logic RESET,
  output logic clock_out,
  output logic tick,
  output logic reset_out
);

  generate
    if (SLOW == 0) begin : g_bypass
      assign clock_out = clock_in;
      assign tick      = 1'b1;
    end else begin : g_div
      localparam logic [SLOW-1:0] TICK_AT = SLOW'((64'd1 << (SLOW - 1)) - 64'd1);

      logic [SLOW-1:0] div = '0;

      always_ff @(posedge clock_in) begin
        if (RESET) begin
          div <= '0;
        end else begin
          div <= div + 1'b1;
        end
      end

      // Straight from the flop MSB so the divided clock cannot glitch.
      assign clock_out = div[SLOW-1];
      assign tick      = (div == TICK_AT);
    end
  endgenerate

  reset_stretcher #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_reset_stretcher (
    .clock_in (clock_in),
    .reset    (RESET),
    .reset_out(reset_out)
  );

endmodule

// File: tb/tb_clockworks.sv
// tb/tb_clockworks.sv - directed self-checking bench for clockworks (SLOW=0, 1 and 3).
module tb_clockworks;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst0 = 1'b0;

  logic co0, tk0, ro0;
  logic co1, tk1, ro1;
  logic co3, tk3, ro3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clockworks #(.SLOW(0), .RESET_CYCLES(16)) u0 (
    .clock_in(clk), .RESET(rst0), .clock_out(co0), .tick(tk0), .reset_out(ro0)
  );
  clockworks #(.SLOW(1), .RESET_CYCLES(1)) u1 (
    .clock_in(clk), .RESET(rst), .clock_out(co1), .tick(tk1), .reset_out(ro1)
  );
  clockworks #(.SLOW(3), .RESET_CYCLES(4)) u3 (
    .clock_in(clk), .RESET(rst), .clock_out(co3), .tick(tk3), .reset_out(ro3)
  );

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  // Expected SLOW=3 / SLOW=1 behaviour k edges after the first edge with RESET=0.
  task automatic chk_run(input int k, input int rc3, input bit with_u1);
    chk("co3", k, co3, (k % 8) >= 4);
    chk("tk3", k, tk3, (k % 8) == 3);
    chk("ro3", k, ro3, k <= rc3);
    if (with_u1) begin
      chk("co1", k, co1, (k % 2) == 1);
      chk("tk1", k, tk1, (k % 2) == 0);
      chk("ro1", k, ro1, k <= 1);
    end
  endtask

  initial begin
    #1;
    chk("pwr_ro0", 0, ro0, 1'b1);
    chk("pwr_co3", 0, co3, 1'b0);
    chk("pwr_ro3", 0, ro3, 1'b1);

    // Power-up without RESET: u0 stretch, u0 bypass clock, u3 free-running from div=0.
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      chk("co0_hi", e, co0, 1'b1);
      @(negedge clk);
      chk("co0_lo", e, co0, 1'b0);
      chk("tk0", e, tk0, 1'b1);
      chk("pwr_ro0", e, ro0, e <= 16);
      chk("pwr_co3", e, co3, (e % 8) >= 4);
      chk("pwr_tk3", e, tk3, (e % 8) == 3);
    end

    // RESET held for 3 edges: outputs frozen at reset values.
    rst = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      chk("rst_co3", e, co3, 1'b0);
      chk("rst_tk3", e, tk3, 1'b0);
      chk("rst_ro3", e, ro3, 1'b1);
      chk("rst_co1", e, co1, 1'b0);
      chk("rst_tk1", e, tk1, 1'b1);
      chk("rst_ro1", e, ro1, 1'b1);
    end
    rst = 1'b0;

    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk_run(k, 4, 1'b1);
    end

    // Advance to div=5 (clock_out high), then reset mid-period.
    for (int k = 1; k <= 5; k++) @(negedge clk);
    chk("mid_co3", 5, co3, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_co3", 0, co3, 1'b0);
    chk("mid_rst_tk3", 0, tk3, 1'b0);
    chk("mid_rst_ro3", 0, ro3, 1'b1);
    rst = 1'b0;

    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk_run(k, 4, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
